// File: rtl/led_pkg.sv
// Shared mode encoding for the LED mode controller.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam mode_t MODE_RESET = MODE_BLINK;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer and debouncer; emits a one-cycle pulse when the
// debounced (active-low) level falls.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= i_btn_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      // A level is adopted only once the counter has reached its limit and
      // the synchronized input still disagrees.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYC)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
          press_reg <= ~sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign o_press = press_reg;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED drive generator: button-cycled off/on/blink/breathe modes with a
// blink-rate prescaler tick exported for analyzer triggering.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BLINK_HZ     = 1,
  parameter int DEBOUNCE_CYC = 270_000,
  parameter int PWM_BITS     = 8,
  parameter int STEP_CYC     = 105_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_n,
  input  logic       i_en,
  output logic       o_LED_1,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = $clog2(HALF);
  localparam int SW   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic                press;
  mode_t               mode_reg;
  mode_t               mode_next;
  logic                led_next;
  logic                led_reg;
  logic                tick_reg;
  logic                phase_reg;
  logic [PW-1:0]       presc_reg;
  logic [PWM_BITS-1:0] pwm_reg;
  logic [PWM_BITS-1:0] duty_reg;
  logic                dir_down_reg;
  logic [SW-1:0]       step_reg;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_btn_n),
    .o_press (press)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_reg <= MODE_RESET;
    end else begin
      mode_reg <= mode_next;
    end
  end

  always_comb begin
    mode_next = mode_reg;
    if (press) begin
      case (mode_reg)
        MODE_OFF:     mode_next = MODE_ON;
        MODE_ON:      mode_next = MODE_BLINK;
        MODE_BLINK:   mode_next = MODE_BREATHE;
        MODE_BREATHE: mode_next = MODE_OFF;
        default:      mode_next = MODE_RESET;
      endcase
    end
  end

  always_comb begin
    led_next = 1'b0;
    if (i_en) begin
      case (mode_reg)
        MODE_OFF:     led_next = 1'b0;
        MODE_ON:      led_next = 1'b1;
        MODE_BLINK:   led_next = phase_reg;
        MODE_BREATHE: led_next = (pwm_reg < duty_reg);
        default:      led_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      led_reg      <= 1'b0;
      tick_reg     <= 1'b0;
      phase_reg    <= 1'b1;
      presc_reg    <= '0;
      pwm_reg      <= '0;
      duty_reg     <= '0;
      dir_down_reg <= 1'b0;
      step_reg     <= '0;
    end else begin
      led_reg <= led_next;
      // A mode change restarts every timebase, even while disabled, and
      // suppresses a coincident terminal-count tick.
      if (press) begin
        tick_reg     <= 1'b0;
        phase_reg    <= 1'b1;
        presc_reg    <= '0;
        pwm_reg      <= '0;
        duty_reg     <= '0;
        dir_down_reg <= 1'b0;
        step_reg     <= '0;
      end else if (!i_en) begin
        tick_reg <= 1'b0;
      end else begin
        if (presc_reg == PW'(HALF - 1)) begin
          presc_reg <= '0;
          phase_reg <= ~phase_reg;
          tick_reg  <= 1'b1;
        end else begin
          presc_reg <= presc_reg + PW'(1);
          tick_reg  <= 1'b0;
        end
        if (mode_reg == MODE_BREATHE) begin
          pwm_reg <= pwm_reg + PWM_BITS'(1);
          if (step_reg == SW'(STEP_CYC - 1)) begin
            step_reg <= '0;
            // Endpoints hold for one step: the flip replaces the move.
            if (!dir_down_reg) begin
              if (duty_reg == DUTY_MAX) dir_down_reg <= 1'b1;
              else                      duty_reg     <= duty_reg + PWM_BITS'(1);
            end else begin
              if (duty_reg == '0) dir_down_reg <= 1'b0;
              else                duty_reg     <= duty_reg - PWM_BITS'(1);
            end
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end
      end
    end
  end

  assign o_LED_1 = led_reg;
  assign o_mode  = mode_reg;
  assign o_tick  = tick_reg;

endmodule
